// File: rtl/sim_bench_ctrl_if.sv
// Bundles the run-control, event and EOS handshake signals of sim_bench_ctrl.
// master = harness/simulation top side, slave = sim_bench_ctrl itself.
interface sim_bench_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int CYC_W  = 32
);
    logic                    start_i;
    logic [NUM_CH-1:0]       evt_i;
    logic [NUM_CH-1:0]       chan_en_i;
    logic                    dut_reset_n_o;
    logic [CYC_W-1:0]        cycle_cnt_o;
    logic [NUM_CH*CNT_W-1:0] evt_cnt_o;
    logic [NUM_CH-1:0]       sat_o;
    logic [2:0]              state_o;
    logic                    eos_req_o;
    logic                    eos_ack_i;
    logic                    timeout_o;
    logic                    done_o;
    logic [NUM_CH*CYC_W-1:0] last_stamp_o;

    modport master (
        output start_i, evt_i, chan_en_i, eos_ack_i,
        input  dut_reset_n_o, cycle_cnt_o, evt_cnt_o, sat_o, state_o,
               eos_req_o, timeout_o, done_o, last_stamp_o
    );

    modport slave (
        input  start_i, evt_i, chan_en_i, eos_ack_i,
        output dut_reset_n_o, cycle_cnt_o, evt_cnt_o, sat_o, state_o,
               eos_req_o, timeout_o, done_o, last_stamp_o
    );
endinterface

// File: rtl/sim_bench_ctrl.sv
// Simulation run controller: DUT reset generation, RUN cycle counting, per-channel
// rising-edge event counters and EOS req/ack handshake. Option: SIM_BENCH_STAMP_EN.
module sim_bench_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int CYC_W       = 32,
    parameter int RST_HOLD    = 11,
    parameter int RUN_LIMIT   = 20000,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             reset_i,
    sim_bench_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RESET = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CYC_W-1:0] HOLD_LAST = CYC_W'(RST_HOLD - 1);
    localparam logic [CYC_W-1:0] RUN_LAST  = CYC_W'(RUN_LIMIT - 1);
    localparam logic [ACK_W-1:0] ACK_LAST  = ACK_W'(ACK_TIMEOUT - 1);

    state_t            state_reg;
    logic              dut_reset_n_reg;
    logic [CYC_W-1:0]  cycle_cnt_reg;
    logic [CYC_W-1:0]  hold_cnt_reg;
    logic [ACK_W-1:0]  ack_cnt_reg;
    logic              eos_req_reg;
    logic              timeout_reg;
    logic              done_reg;
    logic [NUM_CH-1:0] evt_prev_reg;

    logic clear_run;
    logic run_active;

    assign clear_run  = (state_reg == IDLE) && bus.start_i;
    assign run_active = (state_reg == RUN);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg       <= IDLE;
            dut_reset_n_reg <= 1'b0;
            cycle_cnt_reg   <= '0;
            hold_cnt_reg    <= '0;
            ack_cnt_reg     <= '0;
            eos_req_reg     <= 1'b0;
            timeout_reg     <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    dut_reset_n_reg <= 1'b0;
                    if (bus.start_i) begin
                        state_reg     <= RESET;
                        cycle_cnt_reg <= '0;
                        hold_cnt_reg  <= '0;
                        timeout_reg   <= 1'b0;
                        done_reg      <= 1'b0;
                    end
                end
                RESET: begin
                    if (hold_cnt_reg == HOLD_LAST) begin
                        state_reg       <= RUN;
                        dut_reset_n_reg <= 1'b1;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + CYC_W'(1);
                    end
                end
                RUN: begin
                    cycle_cnt_reg <= cycle_cnt_reg + CYC_W'(1);
                    if (cycle_cnt_reg == RUN_LAST) begin
                        state_reg   <= DRAIN;
                        eos_req_reg <= 1'b1;
                        ack_cnt_reg <= '0;
                    end
                end
                DRAIN: begin
                    // Ack wins over an expiring timeout in the same cycle.
                    if (bus.eos_ack_i) begin
                        state_reg   <= DONE;
                        eos_req_reg <= 1'b0;
                        done_reg    <= 1'b1;
                    end else if (ack_cnt_reg == ACK_LAST) begin
                        state_reg   <= DONE;
                        eos_req_reg <= 1'b0;
                        done_reg    <= 1'b1;
                        timeout_reg <= 1'b1;
                    end else begin
                        ack_cnt_reg <= ack_cnt_reg + ACK_W'(1);
                    end
                end
                DONE: begin
                    done_reg <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Edge history runs in every state so a level already high at RUN entry is not an edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            evt_prev_reg <= '0;
        end else begin
            evt_prev_reg <= bus.evt_i;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             sat_reg;
            logic             hit;

            assign hit      = run_active && bus.evt_i[gi] && !evt_prev_reg[gi]
                              && bus.chan_en_i[gi] && !sat_reg;
            assign cnt_next = cnt_reg + CNT_W'(1);

            always_ff @(posedge clk_i) begin
                if (reset_i || clear_run) begin
                    cnt_reg <= '0;
                    sat_reg <= 1'b0;
                end else if (hit) begin
                    cnt_reg <= cnt_next;
                    sat_reg <= &cnt_next;
                end
            end

            assign bus.evt_cnt_o[gi*CNT_W +: CNT_W] = cnt_reg;
            assign bus.sat_o[gi]                    = sat_reg;

`ifdef SIM_BENCH_STAMP_EN
            logic [CYC_W-1:0] stamp_reg;

            always_ff @(posedge clk_i) begin
                if (reset_i || clear_run) begin
                    stamp_reg <= '0;
                end else if (hit) begin
                    stamp_reg <= cycle_cnt_reg;
                end
            end

            assign bus.last_stamp_o[gi*CYC_W +: CYC_W] = stamp_reg;
`endif
        end
    endgenerate

`ifndef SIM_BENCH_STAMP_EN
    assign bus.last_stamp_o = '0;
`endif

    assign bus.dut_reset_n_o = dut_reset_n_reg;
    assign bus.cycle_cnt_o   = cycle_cnt_reg;
    assign bus.state_o       = state_reg;
    assign bus.eos_req_o     = eos_req_reg;
    assign bus.timeout_o     = timeout_reg;
    assign bus.done_o        = done_reg;
endmodule

// File: doc/sim_bench_ctrl.md
Name: sim_bench_ctrl

Overview:
- Synthesizable successor to the per-top simulation harness logic.
- Generates DUT reset, counts clock cycles, and counts rising-edge benchmark events on NUM_CH channels.
- Terminates a run after a cycle limit and requests end-of-simulation (EOS) through a req/ack handshake.
- Sits in each simulation top, between the free-running clock and the DUT, and feeds the fring/shunt EOS path.

Parameters:
- NUM_CH, 4: number of independent event channels.
- CNT_W, 32: width of each event counter.
- CYC_W, 32: width of cycle counter and cycle-limit compare.
- RST_HOLD, 11: cycles dut_reset_n_o is held low after start; legal range 1..2^CYC_W-1.
- RUN_LIMIT, 20000: RUN-state cycles before the run ends.
- ACK_TIMEOUT, 64: cycles to wait for eos_ack_i before forcing DONE.

Ports:
- clk_i  input  1  sole clock; all logic on posedge.
- reset_i  input  1  synchronous, active-high reset.
- start_i  input  1  one-cycle pulse; begins a run from IDLE.
- evt_i  input  NUM_CH  benchmark event level per channel.
- chan_en_i  input  NUM_CH  per-channel count enable.
- dut_reset_n_o  output  1  active-low reset to DUT.
- cycle_cnt_o  output  CYC_W  cycles spent in RUN.
- evt_cnt_o  output  NUM_CH*CNT_W  event counters; channel k occupies bits [k*CNT_W +: CNT_W].
- sat_o  output  NUM_CH  sticky counter-saturated flag per channel.
- state_o  output  3  encoded FSM state.
- eos_req_o  output  1  end-of-simulation request.
- eos_ack_i  input  1  EOS acknowledge.
- timeout_o  output  1  sticky; DONE was reached without an ack.
- done_o  output  1  high in DONE.
- last_stamp_o  output  NUM_CH*CYC_W  per-channel cycle stamp; see Optional Feature.

Behaviour:
- Reset values (reset_i high at posedge):
  - state=IDLE (0).
  - dut_reset_n_o=0.
  - All counters, sat_o, timeout_o, eos_req_o, done_o, last_stamp_o = 0.
  - Event edge-history registers = 0.
- State encoding: IDLE=0, RESET=1, RUN=2, DRAIN=3, DONE=4.
- IDLE:
  - dut_reset_n_o=0.
  - start_i moves to RESET and clears cycle_cnt_o, evt_cnt_o, sat_o, timeout_o and the hold counter.
  - start_i in any other state is ignored.
- RESET:
  - dut_reset_n_o=0 for exactly RST_HOLD cycles counted in RESET, then RUN.
  - dut_reset_n_o reads 1 in the first RUN cycle.
- RUN:
  - dut_reset_n_o=1; cycle_cnt_o increments by 1 each cycle.
  - When cycle_cnt_o == RUN_LIMIT-1 at a posedge, go to DRAIN. cycle_cnt_o then holds RUN_LIMIT.
- Event counting:
  - Active only in RUN.
  - Channel k counts when evt_i[k]=1, the previous sampled evt_i[k]=0, and chan_en_i[k]=1.
  - Edge history updates every cycle in every state. An event level already high on entry to RUN does not count until it falls and rises again.
  - Counters saturate at 2^CNT_W-1 and set sat_o[k]; no wrap.
  - Channels are independent; simultaneous edges on all channels each count once.
- DRAIN:
  - eos_req_o=1. Counting stops; counters hold.
  - eos_ack_i=1 → DONE on the next edge; timeout_o stays 0.
  - No ack within ACK_TIMEOUT cycles → DONE with timeout_o=1.
  - An ack arriving in the same cycle as the timeout expiry counts as an ack (timeout_o=0).
- DONE:
  - eos_req_o=0, done_o=1, dut_reset_n_o=1. All counts hold until reset_i.
- reset_i mid-run, from any state: return to IDLE next edge with all reset values; no EOS request is issued.
- eos_ack_i outside DRAIN: ignored.

Optional Feature:
- Macro: SIM_BENCH_STAMP_EN.
- Defined:
  - On each counted event, last_stamp_o channel k loads the current cycle_cnt_o value (pre-increment).
  - Not updated when saturated.
  - Cleared at start_i and reset_i.
- Undefined: last_stamp_o is tied to 0 and no stamp registers are built.

Test Plan:
- Params RST_HOLD=3, RUN_LIMIT=10, NUM_CH=2. Pulse start_i → dut_reset_n_o low 3 cycles, high on 4th; done_o never high before eos_ack_i.
- During RUN, 5 single-cycle pulses on evt_i[0] with chan_en_i=2'b01, and the same pulses on evt_i[1] → evt_cnt ch0=5, ch1=0, cycle_cnt_o=10 at DRAIN.
- evt_i[1] held high across start through RUN → ch1 count 0; drop then raise once → ch1 count 1.
- CNT_W=3, 9 edges on ch0 → count 7, sat_o[0]=1, ch1 unaffected.
- DRAIN with eos_ack_i asserted 5 cycles in → DONE, timeout_o=0. Repeat with no ack and ACK_TIMEOUT=4 → DONE after 4 cycles, timeout_o=1.
- reset_i pulsed mid-RUN at cycle 6 → state 0, counters 0, eos_req_o never asserted. With SIM_BENCH_STAMP_EN, an event at RUN cycle 7 → last_stamp ch0=7.
